// File: rtl/dig_lock_sender.sv
// Serial lock-code transmitter: guard bits, MSB-first code, then an unlock
// wait window with bounded retries and a success/fail result.
module dig_lock_sender #(
    parameter int   CODE_W    = 4,
    parameter int   GUARD_LEN = 2,
    parameter logic GUARD_BIT = 1'b1,
    parameter int   TIMEOUT   = 3,
    parameter int   MAX_RETRY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CODE_W-1:0] code,
    input  logic              unlock_in,
    output logic              bout,
    output logic              bvalid,
    output logic              busy,
    output logic              done,
    output logic              success,
    output logic              fail
);
    localparam int BW = $clog2(CODE_W + 1);

    typedef enum logic [2:0] {S_IDLE, S_GUARD, S_SEND, S_WAIT, S_DONE} state_t;

    state_t            state;
    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] sh;
    logic [BW-1:0]     bcnt;
    logic [3:0]        gcnt;
    logic [3:0]        tcnt;
    logic [2:0]        rcnt;

    // Outputs are registered: each transition sets the values for the state being entered.
    // bout holds the bit on the wire; sh[CODE_W-1] is the bit that follows it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            code_q  <= '0;
            sh      <= '0;
            bcnt    <= '0;
            gcnt    <= '0;
            tcnt    <= '0;
            rcnt    <= '0;
            bout    <= 1'b0;
            bvalid  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            success <= 1'b0;
            fail    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        code_q  <= code;
                        success <= 1'b0;
                        fail    <= 1'b0;
                        rcnt    <= '0;
                        busy    <= 1'b1;
                        bvalid  <= 1'b1;
                        if (GUARD_LEN == 0) begin
                            state <= S_SEND;
                            bcnt  <= BW'(CODE_W - 1);
                            bout  <= code[CODE_W-1];
                            sh    <= {code[CODE_W-2:0], 1'b0};
                        end else begin
                            state <= S_GUARD;
                            gcnt  <= 4'(GUARD_LEN - 1);
                            bout  <= GUARD_BIT;
                        end
                    end
                end
                S_GUARD: begin
                    if (gcnt == '0) begin
                        state <= S_SEND;
                        bcnt  <= BW'(CODE_W - 1);
                        bout  <= code_q[CODE_W-1];
                        sh    <= {code_q[CODE_W-2:0], 1'b0};
                    end else begin
                        gcnt <= gcnt - 4'd1;
                    end
                end
                S_SEND: begin
                    if (bcnt == '0) begin
                        bout   <= 1'b0;
                        bvalid <= 1'b0;
                        if (unlock_in) begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            success <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                            tcnt  <= 4'(TIMEOUT - 1);
                        end
                    end else begin
                        bcnt <= bcnt - 1'b1;
                        bout <= sh[CODE_W-1];
                        sh   <= {sh[CODE_W-2:0], 1'b0};
                    end
                end
                S_WAIT: begin
                    if (unlock_in) begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        success <= 1'b1;
                    end else if (tcnt == '0) begin
                        if (rcnt < 3'(MAX_RETRY)) begin
                            rcnt   <= rcnt + 3'd1;
                            bvalid <= 1'b1;
                            if (GUARD_LEN == 0) begin
                                state <= S_SEND;
                                bcnt  <= BW'(CODE_W - 1);
                                bout  <= code_q[CODE_W-1];
                                sh    <= {code_q[CODE_W-2:0], 1'b0};
                            end else begin
                                state <= S_GUARD;
                                gcnt  <= 4'(GUARD_LEN - 1);
                                bout  <= GUARD_BIT;
                            end
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            fail  <= 1'b1;
                        end
                    end else begin
                        tcnt <= tcnt - 4'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    bvalid <= 1'b0;
                    bout   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dig_lock_sender.sv
// Directed bench for dig_lock_sender: per-cycle expected outputs are queued
// when a sequence is launched and compared as the DUT produces them.
module tb_dig_lock_sender;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] code = '0;
    logic       unlock_in = 1'b0;
    logic       bout1, bvalid1, busy1, done1, success1, fail1;
    logic       bout2, bvalid2, busy2, done2, success2, fail2;

    always #5 clk = ~clk;

    dig_lock_sender #(.CODE_W(4), .GUARD_LEN(2), .GUARD_BIT(1'b1), .TIMEOUT(3), .MAX_RETRY(1)) dut (
        .clk(clk), .reset(reset), .start(start), .code(code), .unlock_in(unlock_in),
        .bout(bout1), .bvalid(bvalid1), .busy(busy1), .done(done1),
        .success(success1), .fail(fail1)
    );

    dig_lock_sender #(.CODE_W(4), .GUARD_LEN(0), .GUARD_BIT(1'b1), .TIMEOUT(1), .MAX_RETRY(0)) dut2 (
        .clk(clk), .reset(reset), .start(start), .code(code), .unlock_in(unlock_in),
        .bout(bout2), .bvalid(bvalid2), .busy(busy2), .done(done2),
        .success(success2), .fail(fail2)
    );

    // Vector order: {bout, bvalid, busy, done, success, fail}
    logic [5:0] stage[$];
    logic [5:0] sb[$];
    bit         st[32];
    bit         ul[32];
    bit         rs[32];
    logic [3:0] cd[32];
    bit         sel = 1'b0;
    int         errors = 0;
    int         checks = 0;

    task automatic push(input logic b, input logic v, input logic bz, input logic d,
                        input logic s, input logic f);
        stage.push_back({b, v, bz, d, s, f});
    endtask

    task automatic e_guard(input int n);
        for (int i = 0; i < n; i++) push(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic e_code(input logic [3:0] c);
        logic [3:0] cc;
        cc = c;
        for (int i = 3; i >= 0; i--) push(cc[i], 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic e_wait(input int n);
        for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic e_done(input logic s, input logic f);
        push(1'b0, 1'b0, 1'b1, 1'b1, s, f);
    endtask

    task automatic e_idle(input int n, input logic s, input logic f);
        for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b0, 1'b0, s, f);
    endtask

    task automatic clear_stim(input logic [3:0] c);
        stage.delete();
        for (int i = 0; i < 32; i++) begin
            st[i] = 1'b0; ul[i] = 1'b0; rs[i] = 1'b0; cd[i] = c;
        end
    endtask

    // Cycle 0 drives the launching inputs and queues expectations; cycles 1..n are checked.
    task automatic run(input int n, input string tag);
        logic [5:0] obs;
        logic [5:0] exp_v;
        for (int c = 0; c <= n; c++) begin
            @(negedge clk);
            if (c > 0) begin
                obs = sel ? {bout2, bvalid2, busy2, done2, success2, fail2}
                          : {bout1, bvalid1, busy1, done1, success1, fail1};
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $error("FAIL %s cyc%0d scoreboard empty, observed=%b", tag, c, obs);
                end else begin
                    exp_v = sb.pop_front();
                    assert (obs === exp_v) else begin
                        errors++;
                        $error("FAIL %s cyc%0d observed=%b expected=%b", tag, c, obs, exp_v);
                    end
                end
            end
            start = st[c]; code = cd[c]; unlock_in = ul[c]; reset = rs[c];
            if (c == 0) while (stage.size() > 0) sb.push_back(stage.pop_front());
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL %s leftover expectations=%0d required=0", tag, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        // Reset state
        clear_stim(4'b0000);
        rs[0] = 1'b1; rs[1] = 1'b1;
        e_idle(2, 1'b0, 1'b0);
        run(2, "reset");

        // Unlock on the last code bit
        clear_stim(4'b0110);
        st[0] = 1'b1; ul[6] = 1'b1;
        e_guard(2); e_code(4'b0110); e_done(1'b1, 1'b0); e_idle(1, 1'b1, 1'b0);
        run(8, "unlock_last_bit");

        // No unlock: one retry then fail
        clear_stim(4'b0110);
        st[0] = 1'b1;
        e_guard(2); e_code(4'b0110); e_wait(3);
        e_guard(2); e_code(4'b0110); e_wait(3);
        e_done(1'b0, 1'b1); e_idle(1, 1'b0, 1'b1);
        run(20, "retry_fail");

        // Unlock outside the window ignored, then accepted in WAIT
        clear_stim(4'b0110);
        st[0] = 1'b1; ul[2] = 1'b1; ul[4] = 1'b1; ul[8] = 1'b1;
        e_guard(2); e_code(4'b0110); e_wait(2); e_done(1'b1, 1'b0); e_idle(1, 1'b1, 1'b0);
        run(10, "unlock_window");

        // Start while busy ignored; start in DONE ignored, accepted in next IDLE
        clear_stim(4'b1001);
        cd[0] = 4'b0110; st[0] = 1'b1; st[4] = 1'b1; st[19] = 1'b1; st[20] = 1'b1;
        ul[26] = 1'b1;
        e_guard(2); e_code(4'b0110); e_wait(3);
        e_guard(2); e_code(4'b0110); e_wait(3);
        e_done(1'b0, 1'b1); e_idle(1, 1'b0, 1'b1);
        e_guard(2); e_code(4'b1001); e_done(1'b1, 1'b0); e_idle(1, 1'b1, 1'b0);
        run(28, "busy_start_b2b");

        // Reset mid-transmission aborts without done
        clear_stim(4'b0110);
        st[0] = 1'b1; rs[5] = 1'b1; ul[6] = 1'b1;
        e_guard(2); push(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); push(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        e_idle(2, 1'b0, 1'b0);
        run(7, "reset_abort");

        // Unlock on the final WAIT cycle
        clear_stim(4'b1011);
        st[0] = 1'b1; ul[9] = 1'b1;
        e_guard(2); e_code(4'b1011); e_wait(3); e_done(1'b1, 1'b0); e_idle(1, 1'b1, 1'b0);
        run(11, "unlock_last_wait");

        // No guard, single WAIT cycle, no retries
        sel = 1'b1;
        clear_stim(4'b1100);
        st[0] = 1'b1; ul[3] = 1'b1;
        e_code(4'b1100); e_wait(1); e_done(1'b0, 1'b1); e_idle(1, 1'b0, 1'b1);
        run(7, "noguard_noretry");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dig_lock_sender.md
# dig_lock_sender

Serial code transmitter for the digital-lock link. It latches a parallel lock code on `start`, precedes it with guard bits, and shifts it out one bit per clock on `bout`. It then watches the lock detector's `unlock_in` response, retries on timeout, and reports success or failure. It sits on the initiator side of the lock, driving the detector's serial input.

## Interface
- `CODE_W`, 4: lock code width in bits (2..16).
- `GUARD_LEN`, 2: number of guard bits sent before the code (0..15).
- `GUARD_BIT`, 1'b1: value driven on `bout` during guard bits.
- `TIMEOUT`, 3: number of WAIT cycles allowed for `unlock_in` after the last code bit (≥1).
- `MAX_RETRY`, 1: number of retransmissions after the first attempt (0..7).

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request a transmission; sampled only in IDLE.
- `code`  in  CODE_W: lock code; latched on the accepted `start`.
- `unlock_in`  in  1: detector unlock indication (Mealy, same-cycle).
- `bout`  out  1: serial bit to the detector.
- `bvalid`  out  1: `bout` carries a guard or code bit this cycle.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when an attempt sequence ends.
- `success`  out  1: result flag; set with `done` on unlock, held until the next accepted `start`.
- `fail`  out  1: result flag; set with `done` on exhausted retries, held until the next accepted `start`.

## Operation
- States and transitions:
  - IDLE → GUARD on `start`. If `GUARD_LEN`=0, IDLE → SEND directly.
  - GUARD → SEND.
  - SEND → WAIT, or → DONE.
  - WAIT → GUARD for a retry, or → DONE.
  - DONE → IDLE.
- Accepted `start`:
  - latches `code` into the shift register;
  - clears `success`/`fail`;
  - clears the retry counter.
- GUARD: drives `bout`=`GUARD_BIT` with `bvalid`=1 for `GUARD_LEN` cycles.
- SEND:
  - drives the code MSB first, one bit per cycle, `bvalid`=1, for `CODE_W` cycles;
  - shifts a copy of the code, so the latched code is preserved for retries.
- Unlock window: `unlock_in` is sampled only on the last SEND cycle and during WAIT.
  - High on a window cycle → DONE with `success`=1.
  - `unlock_in` outside the window (IDLE, GUARD, earlier SEND bits, DONE) is ignored.
- WAIT: lasts at most `TIMEOUT` cycles, with `bvalid`=0 and `bout`=0. On expiry without unlock:
  - if retry count < `MAX_RETRY`: increment the count and re-enter GUARD, resending the same latched code;
  - otherwise: DONE with `fail`=1.
- DONE: one cycle with `done`=1, then IDLE.
- `start` while `busy` is ignored. Changes on `code` after latching are ignored.
- Counters:
  - bit counter is `$clog2(CODE_W+1)` bits;
  - guard and timeout counters are 4 bits each;
  - retry counter is 3 bits;
  - no counter wraps; each is reloaded on state entry.

## Timing
- Reset:
  - takes effect at the next rising edge;
  - state=IDLE, all counters cleared;
  - `bout`=0, `bvalid`=0, `busy`=0, `done`=0, `success`=0, `fail`=0.
  - Reset asserted mid-transmission aborts with no `done` pulse.
- Let `start` be sampled at edge 0 (cycle numbers = cycles after that edge). With defaults:
  - guard bits in cycles 1–2;
  - code bits in cycles 3–6, MSB in cycle 3;
  - `busy`=1 from cycle 1.
- All outputs are registered or decoded from registered state; no combinational path from `unlock_in` to any output.
- `done` follows the cycle in which unlock is sampled or the timeout expires by exactly one cycle.
- Back-to-back operation: `start` held high in DONE is not accepted; it is accepted in the following IDLE cycle.

## Test plan
- Code 4'b0110, `unlock_in` pulsed high in cycle 6 → `bout` shows 1,1,0,1,1,0 in cycles 1–6; `done`=1 and `success`=1 in cycle 7; IDLE in cycle 8.
- Code 4'b0110, `unlock_in` never high → WAIT in cycles 7–9; retransmission in cycles 10–15; WAIT in cycles 16–18; `done`=1, `fail`=1 in cycle 19; `success`=0.
- `unlock_in` high only in cycles 2 and 4 (outside the window), then high in WAIT cycle 8 → `success` with `done` in cycle 9.
- `start` re-pulsed in cycle 4 with `code`=4'b1001 → ignored; the sequence completes with 0110, and the retry resends 0110.
- `reset` asserted in cycle 5 → cycle 6 shows IDLE with all outputs 0 and no `done`; a new `start` then works normally.
- `MAX_RETRY`=0, `GUARD_LEN`=0, `TIMEOUT`=1, no unlock → code in cycles 1–4, WAIT in cycle 5, `fail` with `done` in cycle 6.
